sevenseg_scan_ctrl: RTL and testbench

Time-multiplexing controller for the 4-digit common-anode seven-segment display. It owns the active-low anode select (AN[3:0]) and the shared active-low segment/dp bus, and scans one digit per slot.
It decodes a 16-bit hex value with double-buffered loading (tear-free, frame-aligned updates), per-digit blanking, leading-zero suppression and 8-level PWM brightness. It sits between the top-level datapath and the board display pins.

---
 rtl/sevenseg_scan_ctrl.sv | 91 +++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: 4-digit common-anode seven-segment scanner with
// double-buffered hex display, blanking, leading-zero suppression and PWM dimming.
module sevenseg_scan_ctrl #(
    parameter int PRESCALE_W = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    input  logic        load,
    input  logic        lzs,
    input  logic [2:0]  bright,
    output logic        pending,
    output logic [3:0]  AN,
    output logic [6:0]  seg,
    output logic        dp
);
    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [PRESCALE_W-1:0] cnt_q;
    logic [1:0]            dig_q;
    logic [15:0]           stg_val_q, disp_val_q;
    logic [3:0]            stg_dp_q, stg_blank_q, disp_dp_q, disp_blank_q;
    logic                  pending_q;
    logic [3:0]            an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  tick, frame_end, sup, on;

    // A suppressed digit keeps its anode only to show a lit decimal point.
    always_comb begin
        tick      = &cnt_q;
        frame_end = tick && dig_q == 2'd3;
        sup       = lzs && dig_q != 2'd0 && (disp_val_q >> {dig_q, 2'b00}) == 16'd0;
        on        = !disp_blank_q[dig_q] && cnt_q != '0
                    && cnt_q[PRESCALE_W-1 -: 3] <= bright
                    && (!sup || disp_dp_q[dig_q]);
        an_d      = on ? ~(4'b0001 << dig_q) : 4'b1111;
        seg_d     = (on && !sup) ? HEX[disp_val_q[{dig_q, 2'b00} +: 4]] : 7'h7F;
        dp_d      = !(on && disp_dp_q[dig_q]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            dig_q        <= '0;
            stg_val_q    <= '0;
            stg_dp_q     <= '0;
            stg_blank_q  <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            disp_blank_q <= '0;
            pending_q    <= 1'b0;
            an_q         <= 4'b1111;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            if (tick)
                dig_q <= dig_q + 2'd1;
            if (load && frame_end) begin
                disp_val_q   <= value;
                disp_dp_q    <= dp_in;
                disp_blank_q <= blank_in;
                pending_q    <= 1'b0;
            end else if (load) begin
                stg_val_q   <= value;
                stg_dp_q    <= dp_in;
                stg_blank_q <= blank_in;
                pending_q   <= 1'b1;
            end else if (frame_end && pending_q) begin
                disp_val_q   <= stg_val_q;
                disp_dp_q    <= stg_dp_q;
                disp_blank_q <= stg_blank_q;
                pending_q    <= 1'b0;
            end
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign pending = pending_q;
    assign AN      = an_q;
    assign seg     = seg_q;
    assign dp      = dp_q;
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl: randomized and directed checks of the scan controller
// against a frame/slot arithmetic model of the display.
module tb_sevenseg_scan_ctrl;
    localparam int P     = 5;
    localparam int SLOT  = 1 << P;
    localparam int FRAME = 4 * SLOT;
    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0, reset = 1'b1, load = 1'b0, lzs = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0, blank_in = '0;
    logic [2:0]  bright = 3'd7;
    logic        pending, dp;
    logic [3:0]  AN;
    logic [6:0]  seg;

    int n_chk = 0, n_fail = 0, cyc = 0;
    logic [15:0] m_val, s_val;
    logic [3:0]  m_dp, m_bl, s_dp, s_bl;
    logic        m_pend;

    sevenseg_scan_ctrl #(.PRESCALE_W(P)) dut (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .blank_in(blank_in),
        .load(load), .lzs(lzs), .bright(bright), .pending(pending),
        .AN(AN), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        {m_val, s_val, m_dp, m_bl, s_dp, s_bl, m_pend} = '0;
    endtask

    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d,
                        input logic [3:0] b, input logic lz, input logic [2:0] br);
        int pos, dg;
        logic sup, on, fe, e_dp;
        logic [3:0] nib, e_an;
        logic [6:0] e_seg;
        @(negedge clk);
        load = ld; value = v; dp_in = d; blank_in = b; lzs = lz; bright = br;
        pos = cyc % SLOT;
        dg  = (cyc / SLOT) % 4;
        nib = m_val[4*dg +: 4];
        sup = lz && dg != 0 && (m_val >> (4*dg)) == 16'd0;
        on  = !m_bl[dg] && pos != 0 && (pos * 8 / SLOT) <= int'(br) && (!sup || m_dp[dg]);
        e_an = 4'b1111;
        if (on) e_an[dg] = 1'b0;
        e_seg = (on && !sup) ? HEX[nib] : 7'h7F;
        e_dp  = !(on && m_dp[dg]);
        fe = (cyc % FRAME) == FRAME - 1;
        if (ld && fe) begin
            m_val = v; m_dp = d; m_bl = b; m_pend = 1'b0;
        end else if (ld) begin
            s_val = v; s_dp = d; s_bl = b; m_pend = 1'b1;
        end else if (fe && m_pend) begin
            m_val = s_val; m_dp = s_dp; m_bl = s_bl; m_pend = 1'b0;
        end
        cyc++;
        @(posedge clk);
        #1;
        chk("AN", AN, e_an);
        chk("seg", seg, e_seg);
        chk("dp", dp, e_dp);
        chk("pending", pending, m_pend);
        load = 1'b0;
    endtask

    task automatic idle(input int n, input logic lz, input logic [2:0] br);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, 4'h0, lz, br);
    endtask

    initial begin
        logic [15:0] sweep [4];
        sweep = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
        repeat (3) @(posedge clk);
        #1;
        chk("reset AN", AN, 4'b1111);
        chk("reset seg", seg, 7'h7F);
        chk("reset dp", dp, 1'b1);
        chk("reset pending", pending, 1'b0);
        reset = 1'b0;
        model_reset();

        step(1'b1, 16'h1234, 4'h0, 4'h0, 1'b0, 3'd7);
        idle(2 * FRAME, 1'b0, 3'd7);
        foreach (sweep[k]) begin
            step(1'b1, sweep[k], 4'h0, 4'h0, 1'b0, 3'd7);
            idle(2 * FRAME, 1'b0, 3'd7);
        end
        step(1'b1, 16'h0005, 4'h0, 4'h0, 1'b1, 3'd7);
        idle(2 * FRAME, 1'b1, 3'd7);
        step(1'b1, 16'h0000, 4'h0, 4'h0, 1'b1, 3'd7);
        idle(2 * FRAME, 1'b1, 3'd7);
        step(1'b1, 16'h0100, 4'h0, 4'h0, 1'b1, 3'd7);
        idle(2 * FRAME, 1'b1, 3'd7);
        step(1'b1, 16'h0000, 4'b1111, 4'b0100, 1'b1, 3'd7);
        idle(2 * FRAME, 1'b1, 3'd7);

        step(1'b1, 16'hAAAA, 4'h0, 4'h0, 1'b0, 3'd7);
        idle(2, 1'b0, 3'd7);
        step(1'b1, 16'hBBBB, 4'h0, 4'h0, 1'b0, 3'd7);
        idle(2 * FRAME, 1'b0, 3'd7);
        while (cyc % FRAME != FRAME - 1) idle(1, 1'b0, 3'd7);
        step(1'b1, 16'hC0DE, 4'b1010, 4'h0, 1'b0, 3'd7);
        idle(2 * FRAME, 1'b0, 3'd7);

        step(1'b1, 16'h8888, 4'h0, 4'b0100, 1'b0, 3'd0);
        idle(2 * FRAME, 1'b0, 3'd0);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 15) == 0, 16'($urandom), 4'($urandom),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                 (i / 200) % 2 == 1, 3'($urandom));

        step(1'b1, 16'h1234, 4'h0, 4'h0, 1'b0, 3'd7);
        idle(2 * FRAME, 1'b0, 3'd7);
        while (cyc % FRAME != 2 * SLOT + 4) idle(1, 1'b0, 3'd7);
        step(1'b1, 16'h5555, 4'h0, 4'h0, 1'b0, 3'd7);
        chk("pre-reset AN", AN, 4'b1011);
        #1 reset = 1'b1;
        #1;
        chk("async reset AN", AN, 4'b1111);
        chk("async reset seg", seg, 7'h7F);
        chk("async reset dp", dp, 1'b1);
        chk("async reset pending", pending, 1'b0);
        #1 reset = 1'b0;
        model_reset();
        idle(2 * FRAME, 1'b0, 3'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
